// File: rtl/lbll_equiv_checker.sv
// Lockstep equivalence checker: drives LFSR vectors to an original and a locked DUT
// and compares their {out, out_valid, ready} per vector, reporting a pass/fail summary.
module lbll_equiv_checker #(
    parameter int          IN_W        = 512,
    parameter int          OUT_W       = 128,
    parameter int          NUM_VEC     = 30,
    parameter int          WAIT_CYCLES = 50,
    parameter int          MODE        = 0,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IN_W-1:0]    dut_in,
    output logic               dut_in_valid,
    input  logic [OUT_W-1:0]   gold_out,
    input  logic [OUT_W-1:0]   lock_out,
    input  logic               gold_out_valid,
    input  logic               lock_out_valid,
    input  logic               gold_ready,
    input  logic               lock_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [15:0]        first_err_idx,
    output logic [OUT_W+1:0]   first_err_diff,
    output logic               timeout
);

    localparam int          WORDS = IN_W / 32;
    localparam int          CW    = OUT_W + 2;
    localparam logic [31:0] TAPS  = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_GEN, S_DRIVE, S_WAIT, S_CMP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     lfsr_q, lfsr_d, lfsr_step;
    logic [IN_W-1:0] din_q, din_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [15:0]     vec_q, vec_d;
    logic [CW-1:0]   gcap_q, gcap_d, lcap_q, lcap_d;
    logic            ghit_q, ghit_d, lhit_q, lhit_d;
    logic            vto_q, vto_d;
    logic [15:0]     err_q, err_d, fidx_q, fidx_d;
    logic [CW-1:0]   fdiff_q, fdiff_d;
    logic            to_q, to_d;
    logic [CW-1:0]   gsmp, lsmp;
    logic            mismatch;

    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

    // Handshake mode records a captured side's valid as 1 by construction.
    assign gsmp = {gold_out, (MODE == 0) ? gold_out_valid : 1'b1, gold_ready};
    assign lsmp = {lock_out, (MODE == 0) ? lock_out_valid : 1'b1, lock_ready};
    assign mismatch = (gcap_q != lcap_q) || vto_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        gcap_d  = gcap_q;
        lcap_d  = lcap_q;
        ghit_d  = ghit_q;
        lhit_d  = lhit_q;
        vto_d   = vto_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fdiff_d = fdiff_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_GAP;
                    err_d   = '0;
                    fidx_d  = '0;
                    fdiff_d = '0;
                    to_d    = 1'b0;
                    vec_d   = '0;
                    lfsr_d  = SEED;
                end
            end
            S_GAP: begin
                state_d = S_GEN;
                cnt_d   = '0;
            end
            S_GEN: begin
                lfsr_d = lfsr_step;
                din_d  = IN_W'({din_q, lfsr_step});
                if (cnt_q == 32'(WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DRIVE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
                gcap_d  = '0;
                lcap_d  = '0;
                ghit_d  = 1'b0;
                lhit_d  = 1'b0;
                vto_d   = 1'b0;
            end
            S_WAIT: begin
                if (MODE == 0) begin
                    if (cnt_q == 32'(WAIT_CYCLES - 1)) begin
                        gcap_d  = gsmp;
                        lcap_d  = lsmp;
                        state_d = S_CMP;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else begin
                    if (!ghit_q && gold_out_valid) begin
                        gcap_d = gsmp;
                        ghit_d = 1'b1;
                    end
                    if (!lhit_q && lock_out_valid) begin
                        lcap_d = lsmp;
                        lhit_d = 1'b1;
                    end
                    if ((ghit_q || gold_out_valid) && (lhit_q || lock_out_valid)) begin
                        state_d = S_CMP;
                    end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                        vto_d   = 1'b1;
                        to_d    = 1'b1;
                        state_d = S_CMP;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_CMP: begin
                if (mismatch) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    if (err_q == 16'd0) begin
                        fidx_d  = vec_q;
                        fdiff_d = gcap_q ^ lcap_q;
                    end
                end
                if (vec_q == 16'(NUM_VEC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 16'd1;
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            din_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            gcap_q  <= '0;
            lcap_q  <= '0;
            ghit_q  <= 1'b0;
            lhit_q  <= 1'b0;
            vto_q   <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
            fdiff_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            gcap_q  <= gcap_d;
            lcap_q  <= lcap_d;
            ghit_q  <= ghit_d;
            lhit_q  <= lhit_d;
            vto_q   <= vto_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fdiff_q <= fdiff_d;
            to_q    <= to_d;
        end
    end

    assign dut_in         = din_q;
    assign dut_in_valid   = (state_q == S_DRIVE);
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign pass           = (state_q == S_DONE) && (err_q == 16'd0);
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_diff = fdiff_q;
    assign timeout        = to_q;

endmodule

// File: tb/tb_lbll_equiv_checker.sv
// Directed bench: a default-size fixed-window checker and a small handshake-mode checker,
// each fed by 3-cycle registered XOR-fold DUT stubs.
module tb_lbll_equiv_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: defaults, MODE 0 ----------------
    logic         start_a = 1'b0;
    logic [511:0] din_a;
    logic         dv_a, busy_a, done_a, pass_a, to_a;
    logic [127:0] gout_a, lout_a;
    logic         gv_a, lv_a;
    logic [15:0]  err_a, fidx_a;
    logic [129:0] fdiff_a;
    logic [127:0] h1a = '0, h2a = '0, h3a = '0;
    logic         v1a = 1'b0, v2a = 1'b0, v3a = 1'b0;
    logic         inject = 1'b0, flip_a = 1'b0;
    int           lcnt_a = 0;

    lbll_equiv_checker u_a (
        .clk(clk), .rst(rst), .start(start_a),
        .dut_in(din_a), .dut_in_valid(dv_a),
        .gold_out(gout_a), .lock_out(lout_a),
        .gold_out_valid(gv_a), .lock_out_valid(lv_a),
        .gold_ready(1'b1), .lock_ready(1'b1),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_idx(fidx_a),
        .first_err_diff(fdiff_a), .timeout(to_a)
    );

    always @(posedge clk) begin
        h1a <= din_a[127:0] ^ din_a[255:128] ^ din_a[383:256] ^ din_a[511:384];
        h2a <= h1a;  h3a <= h2a;
        v1a <= dv_a; v2a <= v1a; v3a <= v2a;
        if (start_a && !busy_a) lcnt_a <= 0;
        else if (dv_a) begin
            lcnt_a <= lcnt_a + 1;
            flip_a <= inject && (lcnt_a == 5);
        end
    end
    assign gout_a = h3a;
    assign gv_a   = v3a;
    assign lout_a = h3a ^ (flip_a ? 128'h80 : 128'h0);
    assign lv_a   = v3a;

    // ---------------- instance B: MODE 1, lock never valid ----------------
    logic         start_b = 1'b0;
    logic [63:0]  din_b;
    logic         dv_b, busy_b, done_b, pass_b, to_b;
    logic [15:0]  gout_b;
    logic [15:0]  err_b, fidx_b;
    logic [17:0]  fdiff_b;
    logic [15:0]  h1b = '0, h2b = '0, h3b = '0;
    logic         v1b = 1'b0, v2b = 1'b0, v3b = 1'b0;

    lbll_equiv_checker #(.IN_W(64), .OUT_W(16), .NUM_VEC(4), .MODE(1), .TIMEOUT(20)) u_b (
        .clk(clk), .rst(rst), .start(start_b),
        .dut_in(din_b), .dut_in_valid(dv_b),
        .gold_out(gout_b), .lock_out(h3b),
        .gold_out_valid(v3b), .lock_out_valid(1'b0),
        .gold_ready(1'b1), .lock_ready(1'b1),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_idx(fidx_b),
        .first_err_diff(fdiff_b), .timeout(to_b)
    );

    always @(posedge clk) begin
        h1b <= din_b[15:0] ^ din_b[31:16] ^ din_b[47:32] ^ din_b[63:48];
        h2b <= h1b;  h3b <= h2b;
        v1b <= dv_b; v2b <= v1b; v3b <= v2b;
    end
    assign gout_b = h3b;

    // First vector from SEED=1: 80200003 then C0300002, first word in the MSBs.
    localparam logic [63:0] FIRST_V = 64'h8020_0003_C030_0002;

    task automatic run_a(input int mid_at, output int n, output logic [63:0] fv);
        logic got;
        got = 1'b0;
        fv  = '0;
        n   = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_busy_rise", busy_a, 1);
        while (!done_a && n < 5000) begin
            if (dv_a && !got) begin
                fv  = din_a[511:448];
                got = 1'b1;
            end
            start_a = (n == mid_at);
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
    endtask

    int          cyc;
    logic [63:0] fv;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy_a, 0);
        chk("rst_done",  done_a, 0);
        chk("rst_pass",  pass_a, 0);
        chk("rst_dv",    dv_a, 0);
        chk("rst_din",   din_a, 0);
        chk("rst_err",   err_a, 0);
        chk("rst_fdiff", fdiff_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // equal DUTs, with an ignored start pulse mid-run
        run_a(100, cyc, fv);
        chk("a_len",      cyc, 30 * 69);
        chk("a_first_v",  fv, FIRST_V);
        chk("a_pass",     pass_a, 1);
        chk("a_err",      err_a, 0);
        chk("a_fidx",     fidx_a, 0);
        chk("a_timeout",  to_a, 0);
        repeat (5) @(negedge clk);
        chk("a_done_held", done_a, 1);

        // lock_out[7] flipped on vector 5 only; diff bit = 7 + 2
        inject = 1'b1;
        run_a(-1, cyc, fv);
        inject = 1'b0;
        chk("flip_err",   err_a, 1);
        chk("flip_fidx",  fidx_a, 5);
        chk("flip_fdiff", fdiff_a, 130'h200);
        chk("flip_pass",  pass_a, 0);
        chk("flip_done",  done_a, 1);

        // reset during WAIT
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_busy", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy",    busy_a, 0);
        chk("mid_rst_done",    done_a, 0);
        chk("mid_rst_dv",      dv_a, 0);
        chk("mid_rst_din",     din_a, 0);
        chk("mid_rst_err",     err_a, 0);
        chk("mid_rst_timeout", to_a, 0);
        rst = 1'b0;
        @(negedge clk);
        run_a(-1, cyc, fv);
        chk("rerun_first_v", fv, FIRST_V);
        chk("rerun_len",     cyc, 30 * 69);
        chk("rerun_pass",    pass_a, 1);

        // handshake mode, lock side never valid
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        fv  = '0;
        while (!done_b && cyc < 1000) begin
            if (dv_b && fv == 64'h0) fv = din_b;
            @(negedge clk);
            cyc++;
        end
        chk("b_len",     cyc, 4 * 25);
        chk("b_first_v", fv, FIRST_V);
        chk("b_err",     err_b, 4);
        chk("b_timeout", to_b, 1);
        chk("b_fidx",    fidx_b, 0);
        chk("b_fdiff",   fdiff_b, 18'h1_0047);
        chk("b_pass",    pass_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
